// File: rtl/eth_phy_10g_rx_block_lock.sv
`default_nettype none
// ============================================================================
// Module   : eth_phy_10g_rx_block_lock
// Purpose  : 10GBASE-R receive block-lock FSM; bit-slips the frame aligner
//            until sync headers are stable and then monitors them while locked.
// Revision : 1.0  initial release
// ============================================================================
module eth_phy_10g_rx_block_lock #(
    parameter int HDR_WIDTH           = 2,
    parameter int SH_CNT_MAX          = 64,
    parameter int SH_INVALID_MAX      = 16,
    parameter int BITSLIP_HIGH_CYCLES = 1,
    parameter int BITSLIP_LOW_CYCLES  = 8,
    parameter int SLIP_CNT_WIDTH      = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [HDR_WIDTH-1:0]      serdes_rx_hdr,
    input  logic                      serdes_rx_hdr_valid,
    output logic                      serdes_rx_bitslip,
    output logic                      rx_block_lock,
    output logic                      rx_sh_invalid,
    output logic [SLIP_CNT_WIDTH-1:0] rx_slip_count
);

    localparam int c_SH_W    = $clog2(SH_CNT_MAX + 1);
    localparam int c_INV_W   = $clog2(SH_INVALID_MAX + 1);
    localparam int c_TMR_MAX = (BITSLIP_HIGH_CYCLES > BITSLIP_LOW_CYCLES) ?
                               BITSLIP_HIGH_CYCLES : BITSLIP_LOW_CYCLES;
    localparam int c_TMR_W   = $clog2(c_TMR_MAX + 1);

    localparam logic [c_SH_W-1:0]  c_SH_MAX    = c_SH_W'(SH_CNT_MAX);
    localparam logic [c_INV_W-1:0] c_INV_MAX   = c_INV_W'(SH_INVALID_MAX);
    localparam logic [c_TMR_W-1:0] c_HIGH_LOAD = c_TMR_W'(BITSLIP_HIGH_CYCLES - 1);
    // SLIP_WAIT lasts LOW-1 cycles; the first SEARCH cycle completes the LOW-cycle
    // quiet period on serdes_rx_bitslip, so slips repeat every HIGH+LOW cycles.
    localparam logic [c_TMR_W-1:0] c_WAIT_LOAD =
        c_TMR_W'((BITSLIP_LOW_CYCLES > 1) ? BITSLIP_LOW_CYCLES - 2 : 0);
    localparam bit                 c_HAS_WAIT  = (BITSLIP_LOW_CYCLES > 1);

    typedef enum logic [1:0] {
        S_SEARCH    = 2'd0,
        S_SLIP_HIGH = 2'd1,
        S_SLIP_WAIT = 2'd2,
        S_LOCKED    = 2'd3
    } state_t;

    state_t                    r_state,    w_state_nx;
    logic [c_SH_W-1:0]         r_sh_cnt,   w_sh_cnt_nx;
    logic [c_INV_W-1:0]        r_inv_cnt,  w_inv_cnt_nx;
    logic [c_TMR_W-1:0]        r_tmr,      w_tmr_nx;
    logic                      r_bitslip,  w_bitslip_nx;
    logic                      r_lock,     w_lock_nx;
    logic                      r_sh_inv,   w_sh_inv_nx;
    logic [SLIP_CNT_WIDTH-1:0] r_slip_cnt, w_slip_cnt_nx;

    logic                      w_hdr_ok;
    logic                      w_start_slip;
    logic [c_SH_W-1:0]         w_sh_inc;
    logic [c_INV_W-1:0]        w_inv_inc;

    assign w_hdr_ok  = serdes_rx_hdr[1] ^ serdes_rx_hdr[0];
    assign w_sh_inc  = r_sh_cnt + c_SH_W'(1);
    assign w_inv_inc = r_inv_cnt + c_INV_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_SEARCH;
            r_sh_cnt   <= '0;
            r_inv_cnt  <= '0;
            r_tmr      <= '0;
            r_bitslip  <= 1'b0;
            r_lock     <= 1'b0;
            r_sh_inv   <= 1'b0;
            r_slip_cnt <= '0;
        end else begin
            r_state    <= w_state_nx;
            r_sh_cnt   <= w_sh_cnt_nx;
            r_inv_cnt  <= w_inv_cnt_nx;
            r_tmr      <= w_tmr_nx;
            r_bitslip  <= w_bitslip_nx;
            r_lock     <= w_lock_nx;
            r_sh_inv   <= w_sh_inv_nx;
            r_slip_cnt <= w_slip_cnt_nx;
        end
    end

    always_comb begin
        w_state_nx    = r_state;
        w_sh_cnt_nx   = r_sh_cnt;
        w_inv_cnt_nx  = r_inv_cnt;
        w_tmr_nx      = r_tmr;
        w_bitslip_nx  = 1'b0;
        w_lock_nx     = 1'b0;
        w_sh_inv_nx   = 1'b0;
        w_slip_cnt_nx = r_slip_cnt;
        w_start_slip  = 1'b0;

        case (r_state)
            S_SEARCH: begin
                if (serdes_rx_hdr_valid) begin
                    if (!w_hdr_ok) begin
                        w_sh_inv_nx  = 1'b1;
                        w_start_slip = 1'b1;
                    end else if (w_sh_inc == c_SH_MAX) begin
                        w_state_nx   = S_LOCKED;
                        w_lock_nx    = 1'b1;
                        w_sh_cnt_nx  = '0;
                        w_inv_cnt_nx = '0;
                    end else begin
                        w_sh_cnt_nx  = w_sh_inc;
                    end
                end
            end
            S_LOCKED: begin
                w_lock_nx = 1'b1;
                if (serdes_rx_hdr_valid) begin
                    w_sh_inv_nx = !w_hdr_ok;
                    // Loss of lock wins over a window completing on the same header.
                    if (!w_hdr_ok && (w_inv_inc == c_INV_MAX)) begin
                        w_start_slip = 1'b1;
                    end else if (w_sh_inc == c_SH_MAX) begin
                        w_sh_cnt_nx  = '0;
                        w_inv_cnt_nx = '0;
                    end else begin
                        w_sh_cnt_nx  = w_sh_inc;
                        w_inv_cnt_nx = w_hdr_ok ? r_inv_cnt : w_inv_inc;
                    end
                end
            end
            S_SLIP_HIGH: begin
                if (r_tmr == '0) begin
                    if (c_HAS_WAIT) begin
                        w_state_nx = S_SLIP_WAIT;
                        w_tmr_nx   = c_WAIT_LOAD;
                    end else begin
                        w_state_nx = S_SEARCH;
                    end
                end else begin
                    w_bitslip_nx = 1'b1;
                    w_tmr_nx     = r_tmr - c_TMR_W'(1);
                end
            end
            S_SLIP_WAIT: begin
                if (r_tmr == '0) begin
                    w_state_nx = S_SEARCH;
                end else begin
                    w_tmr_nx   = r_tmr - c_TMR_W'(1);
                end
            end
            default: begin
                w_state_nx = S_SEARCH;
            end
        endcase

        if (w_start_slip) begin
            w_state_nx    = S_SLIP_HIGH;
            w_bitslip_nx  = 1'b1;
            w_lock_nx     = 1'b0;
            w_sh_cnt_nx   = '0;
            w_inv_cnt_nx  = '0;
            w_tmr_nx      = c_HIGH_LOAD;
            w_slip_cnt_nx = (&r_slip_cnt) ? r_slip_cnt : r_slip_cnt + SLIP_CNT_WIDTH'(1);
        end
    end

    assign serdes_rx_bitslip = r_bitslip;
    assign rx_block_lock     = r_lock;
    assign rx_sh_invalid     = r_sh_inv;
    assign rx_slip_count     = r_slip_cnt;

endmodule
`default_nettype wire

// File: tb/tb_eth_phy_10g_rx_block_lock.sv
`default_nettype none
// ============================================================================
// Module   : tb_eth_phy_10g_rx_block_lock
// Purpose  : Directed, self-checking bench for the RX block-lock FSM.
// Revision : 1.0  initial release
// ============================================================================
module tb_eth_phy_10g_rx_block_lock;

    localparam int SH_MAX  = 64;
    localparam int INV_MAX = 16;
    localparam int HI      = 1;
    localparam int LO      = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] serdes_rx_hdr = 2'b01;
    logic       serdes_rx_hdr_valid = 1'b0;
    logic       serdes_rx_bitslip;
    logic       rx_block_lock;
    logic       rx_sh_invalid;
    logic [7:0] rx_slip_count;

    int checks = 0;
    int errors = 0;

    eth_phy_10g_rx_block_lock dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .serdes_rx_hdr       (serdes_rx_hdr),
        .serdes_rx_hdr_valid (serdes_rx_hdr_valid),
        .serdes_rx_bitslip   (serdes_rx_bitslip),
        .rx_block_lock       (rx_block_lock),
        .rx_sh_invalid       (rx_sh_invalid),
        .rx_slip_count       (rx_slip_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: after a slip, headers are ignored for HI+LO-1 edges and the slip
    // request is visible for HI cycles; otherwise headers are counted per window.
    int m_good = 0, m_bad = 0, m_quiet = 0, m_hi = 0, m_slips = 0;
    bit m_lock = 0, m_inv = 0, m_is_bad = 0;

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_good = 0; m_bad = 0; m_quiet = 0; m_hi = 0; m_slips = 0;
            m_lock = 0; m_inv = 0;
        end else begin
            m_inv = 0;
            if (m_hi > 0) m_hi--;
            if (m_quiet > 0) begin
                m_quiet--;
            end else if (serdes_rx_hdr_valid) begin
                m_is_bad = (serdes_rx_hdr == 2'b00) || (serdes_rx_hdr == 2'b11);
                m_inv = m_is_bad;
                if (m_lock) begin
                    m_good++;
                    if (m_is_bad) m_bad++;
                end else if (!m_is_bad) begin
                    m_good++;
                end
                if ((m_is_bad && !m_lock) || (m_lock && m_bad == INV_MAX)) begin
                    m_lock = 0; m_good = 0; m_bad = 0;
                    m_hi = HI; m_quiet = HI + LO - 1;
                    if (m_slips < 255) m_slips++;
                end else if (m_good == SH_MAX) begin
                    m_lock = 1; m_good = 0; m_bad = 0;
                end
            end
        end
    end

    initial forever begin
        @(negedge clk);
        check("lock",    int'(rx_block_lock),     int'(m_lock));
        check("bitslip", int'(serdes_rx_bitslip), int'(m_hi > 0));
        check("sh_inv",  int'(rx_sh_invalid),     int'(m_inv));
        check("slips",   int'(rx_slip_count),     m_slips);
    end

    // Inputs change just after a falling edge; outputs are read at the next one.
    task automatic drive(input logic [1:0] h, input logic v);
        serdes_rx_hdr       = h;
        serdes_rx_hdr_valid = v;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        serdes_rx_hdr_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_lock",    int'(rx_block_lock), 0);
        check("rst_bitslip", int'(serdes_rx_bitslip), 0);
        check("rst_slips",   int'(rx_slip_count), 0);
        rst_n = 1'b1;
    endtask

    initial begin
        int n;
        @(negedge clk);

        // Clean acquisition: lock on the 64th valid header, no slips.
        do_reset();
        check("rst_sh_inv", int'(rx_sh_invalid), 0);
        repeat (63) drive(2'b01, 1'b1);
        check("acq_lock_63", int'(rx_block_lock), 0);
        drive(2'b10, 1'b1);
        check("acq_lock_64", int'(rx_block_lock), 1);
        check("acq_slips", int'(rx_slip_count), 0);

        // Invalid header in SEARCH after 63 good ones.
        do_reset();
        repeat (63) drive(2'b01, 1'b1);
        drive(2'b11, 1'b1);
        check("srch_inv_pulse", int'(rx_sh_invalid), 1);
        check("srch_bitslip",   int'(serdes_rx_bitslip), 1);
        check("srch_slips",     int'(rx_slip_count), 1);
        drive(2'b00, 1'b1);
        check("srch_bitslip_1cyc", int'(serdes_rx_bitslip), 0);
        repeat (7) drive(2'b00, 1'b1);
        check("srch_settle_slips", int'(rx_slip_count), 1);
        check("srch_settle_lock",  int'(rx_block_lock), 0);
        repeat (64) drive(2'b01, 1'b1);
        check("srch_relock", int'(rx_block_lock), 1);

        // Locked window with 15 invalids keeps lock.
        for (int i = 0; i < 64; i++) drive((i < 15) ? 2'b00 : 2'b01, 1'b1);
        check("lk15_lock",  int'(rx_block_lock), 1);
        check("lk15_slips", int'(rx_slip_count), 1);

        // Every other header invalid: 16th invalid is header 32.
        for (int i = 0; i < 31; i++) drive((i % 2 == 1) ? 2'b11 : 2'b10, 1'b1);
        check("lk16_before", int'(rx_block_lock), 1);
        drive(2'b11, 1'b1);
        check("lk16_lock",    int'(rx_block_lock), 0);
        check("lk16_bitslip", int'(serdes_rx_bitslip), 1);
        check("lk16_slips",   int'(rx_slip_count), 2);
        repeat (8) drive(2'b01, 1'b1);
        repeat (64) drive(2'b01, 1'b1);
        check("lk_relock", int'(rx_block_lock), 1);

        // 64th header is also the 16th invalid: loss of lock wins.
        for (int i = 0; i < 63; i++) drive((i % 4 == 3) ? 2'b00 : 2'b01, 1'b1);
        check("sim_before", int'(rx_block_lock), 1);
        drive(2'b00, 1'b1);
        check("sim_lock",    int'(rx_block_lock), 0);
        check("sim_bitslip", int'(serdes_rx_bitslip), 1);
        check("sim_slips",   int'(rx_slip_count), 3);

        // Unqualified invalid data interleaved with good headers.
        do_reset();
        for (int i = 0; i < 63; i++) begin
            drive(2'b01, 1'b1);
            drive(2'b11, 1'b0);
        end
        check("qual_before", int'(rx_block_lock), 0);
        drive(2'b01, 1'b1);
        check("qual_lock",  int'(rx_block_lock), 1);
        check("qual_slips", int'(rx_slip_count), 0);
        drive(2'b00, 1'b0);

        // Permanent invalid data: slip period and saturation.
        do_reset();
        drive(2'b00, 1'b1);
        check("perm_first", int'(serdes_rx_bitslip), 1);
        n = 0;
        do begin
            drive(2'b00, 1'b1);
            n++;
        end while (!serdes_rx_bitslip && n < 20);
        check("perm_period", n, HI + LO);
        repeat (260 * (HI + LO)) drive(2'b00, 1'b1);
        check("perm_saturate", int'(rx_slip_count), 255);

        // Asynchronous reset in the middle of a slip.
        do_reset();
        repeat (5) drive(2'b01, 1'b1);
        drive(2'b11, 1'b1);
        check("ar_bitslip_hi", int'(serdes_rx_bitslip), 1);
        #2 rst_n = 1'b0;
        #1;
        check("ar_bitslip_lo", int'(serdes_rx_bitslip), 0);
        check("ar_slips",      int'(rx_slip_count), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (63) drive(2'b01, 1'b1);
        check("ar_lock_63", int'(rx_block_lock), 0);
        drive(2'b01, 1'b1);
        check("ar_lock_64", int'(rx_block_lock), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        errors++;
        $display("FAIL timeout: simulation did not complete");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
